// File: rtl/regfile_arbiter.sv
// regfile_arbiter: shares the single register-file port between the CPU datapath
// (port A, read/write) and the LCD scanner (port B, read-only), and sequences the
// CLEAR operation as a NUM_REGS-cycle zero-write sweep.
// Build option: define REGFILE_ARB_FIXED_PRIO_EN for fixed A-over-B priority on a
// tie; otherwise ties are resolved round-robin.
module regfile_arbiter #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int NUM_REGS = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic [ADDR_W-1:0] b_addr,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    input  logic              clear_req,
    output logic              clear_busy,
    output logic [ADDR_W-1:0] rf_addr,
    output logic              rf_we,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [DATA_W-1:0] rf_rdata
);

    // One spare bit lets the sweep counter reach NUM_REGS without wrapping.
    localparam int               CNT_W      = ADDR_W + 1;
    localparam logic [CNT_W-1:0] SWEEP_LAST = CNT_W'(NUM_REGS);

    // PEND is the cycle after clear_req: in-flight accesses drain, no new grants.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PEND,
        ST_CLEAR
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [CNT_W-1:0] r_sweepCnt;
    logic             r_aIsRead;
    logic             w_eligA;
    logic             w_eligB;
    logic             w_grantA;
    logic             w_grantB;
`ifndef REGFILE_ARB_FIXED_PRIO_EN
    logic             r_lastGrantB;
`endif

    // A port granted this cycle has already dropped out of the next arbitration.
    assign w_eligA    = a_req && !a_gnt;
    assign w_eligB    = b_req && !b_gnt;
    assign clear_busy = (r_state != ST_IDLE);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state and grant decision; CLEAR beats any same-cycle request.
    always_comb begin
        w_nextState = r_state;
        w_grantA    = 1'b0;
        w_grantB    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (clear_req) begin
                    w_nextState = ST_PEND;
                end else if (w_eligA && w_eligB) begin
`ifdef REGFILE_ARB_FIXED_PRIO_EN
                    w_grantA = 1'b1;
`else
                    w_grantA = r_lastGrantB;
                    w_grantB = !r_lastGrantB;
`endif
                end else begin
                    w_grantA = w_eligA;
                    w_grantB = w_eligB;
                end
            end
            ST_PEND: begin
                w_nextState = ST_CLEAR;
            end
            ST_CLEAR: begin
                if (r_sweepCnt == SWEEP_LAST) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

`ifndef REGFILE_ARB_FIXED_PRIO_EN
    // Remember who was served last so the other side wins the next tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lastGrantB <= 1'b1;
        end else if (w_grantA) begin
            r_lastGrantB <= 1'b0;
        end else if (w_grantB) begin
            r_lastGrantB <= 1'b1;
        end
    end
`endif

    // Register-file bus: a granted access, a sweep write, or idle with address held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_gnt      <= 1'b0;
            b_gnt      <= 1'b0;
            r_aIsRead  <= 1'b0;
            rf_addr    <= '0;
            rf_we      <= 1'b0;
            rf_wdata   <= '0;
            r_sweepCnt <= '0;
        end else begin
            a_gnt     <= w_grantA;
            b_gnt     <= w_grantB;
            r_aIsRead <= w_grantA && !a_we;
            rf_we     <= 1'b0;
            if (w_grantA) begin
                rf_addr  <= a_addr;
                rf_we    <= a_we;
                rf_wdata <= a_wdata;
            end else if (w_grantB) begin
                rf_addr <= b_addr;
            end else if (r_state == ST_PEND) begin
                rf_addr    <= '0;
                rf_we      <= 1'b1;
                rf_wdata   <= '0;
                r_sweepCnt <= CNT_W'(1);
            end else if ((r_state == ST_CLEAR) && (r_sweepCnt != SWEEP_LAST)) begin
                rf_addr    <= r_sweepCnt[ADDR_W-1:0];
                rf_we      <= 1'b1;
                rf_wdata   <= '0;
                r_sweepCnt <= r_sweepCnt + CNT_W'(1);
            end
        end
    end

    // Capture read data at the end of the grant cycle; independent of CLEAR so an
    // in-flight read still returns while the sweep starts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_rvalid <= 1'b0;
            a_rdata  <= '0;
            b_rvalid <= 1'b0;
            b_rdata  <= '0;
        end else begin
            a_rvalid <= r_aIsRead;
            b_rvalid <= b_gnt;
            if (r_aIsRead) begin
                a_rdata <= rf_rdata;
            end
            if (b_gnt) begin
                b_rdata <= rf_rdata;
            end
        end
    end

endmodule

// File: tb/tb_regfile_arbiter.sv
// tb_regfile_arbiter: drives regfile_arbiter against a behavioural 16x16 register
// file; read results are queued when a read is issued and popped on rvalid.
module tb_regfile_arbiter;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 16;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_gnt;
    logic              a_rvalid;
    logic [DATA_W-1:0] a_rdata;
    logic              b_req;
    logic [ADDR_W-1:0] b_addr;
    logic              b_gnt;
    logic              b_rvalid;
    logic [DATA_W-1:0] b_rdata;
    logic              clear_req;
    logic              clear_busy;
    logic [ADDR_W-1:0] rf_addr;
    logic              rf_we;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] rf_rdata;

    logic [DATA_W-1:0] rfMem  [NUM_REGS];
    logic [DATA_W-1:0] expMem [NUM_REGS];
    logic [DATA_W-1:0] aQ [$];
    logic [DATA_W-1:0] bQ [$];
    int checks = 0;
    int errors = 0;

    // 50 MHz clock
    always #10 clk = ~clk;

    regfile_arbiter #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .NUM_REGS(NUM_REGS)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .a_req     (a_req),
        .a_we      (a_we),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_gnt     (a_gnt),
        .a_rvalid  (a_rvalid),
        .a_rdata   (a_rdata),
        .b_req     (b_req),
        .b_addr    (b_addr),
        .b_gnt     (b_gnt),
        .b_rvalid  (b_rvalid),
        .b_rdata   (b_rdata),
        .clear_req (clear_req),
        .clear_busy(clear_busy),
        .rf_addr   (rf_addr),
        .rf_we     (rf_we),
        .rf_wdata  (rf_wdata),
        .rf_rdata  (rf_rdata)
    );

    // Behavioural register file: synchronous write, combinational read.
    always @(posedge clk) begin
        if (rf_we) rfMem[rf_addr] <= rf_wdata;
    end
    assign rf_rdata = rfMem[rf_addr];

    // Outputs are sampled and inputs changed on the falling edge.
    task automatic nextCycle;
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset_n = 1'b0; a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_addr = '0; clear_req = 1'b0;
        nextCycle();
        nextCycle();
        checks++;
        if ({a_gnt, a_rvalid, b_gnt, b_rvalid, clear_busy, rf_we} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl got %b want 000000",
                     {a_gnt, a_rvalid, b_gnt, b_rvalid, clear_busy, rf_we});
        end
        checks++;
        if ({a_rdata, b_rdata, rf_wdata, rf_addr} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_data got %h want 0", {a_rdata, b_rdata, rf_wdata, rf_addr});
        end
        reset_n = 1'b1;
        nextCycle();
        checks++;
        if ({a_gnt, a_rvalid, b_gnt, b_rvalid, clear_busy, rf_we} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_release got %b want 000000",
                     {a_gnt, a_rvalid, b_gnt, b_rvalid, clear_busy, rf_we});
        end
    endtask

    task automatic test_a_write;
        a_req = 1'b1; a_we = 1'b1; a_addr = 4'd3; a_wdata = 16'h00A5;
        expMem[3] = 16'h00A5;
        nextCycle();
        checks++;
        if ({a_gnt, b_gnt, rf_we} !== 3'b101) begin
            errors++;
            $display("[TB] FAIL a_write_gnt got %b want 101", {a_gnt, b_gnt, rf_we});
        end
        checks++;
        if ({rf_addr, rf_wdata} !== {4'd3, 16'h00A5}) begin
            errors++;
            $display("[TB] FAIL a_write_bus got %h/%h want 3/00a5", rf_addr, rf_wdata);
        end
        a_req = 1'b0;
        nextCycle();
        checks++;
        if ({a_gnt, a_rvalid, rf_we} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL a_write_after got %b want 000", {a_gnt, a_rvalid, rf_we});
        end
    endtask

    task automatic test_a_read;
        logic [DATA_W-1:0] expData;
        a_req = 1'b1; a_we = 1'b0; a_addr = 4'd3;
        aQ.push_back(expMem[3]);
        nextCycle();
        checks++;
        if ({a_gnt, rf_we, rf_addr} !== {2'b10, 4'd3}) begin
            errors++;
            $display("[TB] FAIL a_read_gnt got %b/%b/%h want 1/0/3", a_gnt, rf_we, rf_addr);
        end
        a_req = 1'b0;
        nextCycle();
        checks++;
        if (a_rvalid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL a_read_rvalid got %b want 1", a_rvalid);
        end else begin
            expData = aQ.pop_front();
            checks++;
            if (a_rdata !== expData) begin
                errors++;
                $display("[TB] FAIL a_read_data got %h want %h", a_rdata, expData);
            end
        end
        nextCycle();
        checks++;
        if ({a_gnt, a_rvalid, a_rdata} !== {2'b00, expMem[3]}) begin
            errors++;
            $display("[TB] FAIL a_read_single got %b/%b/%h want 0/0/%h",
                     a_gnt, a_rvalid, a_rdata, expMem[3]);
        end
    endtask

    task automatic test_b_read;
        logic [DATA_W-1:0] expData;
        a_req = 1'b1; a_we = 1'b1; a_addr = 4'd5; a_wdata = 16'h1234;
        expMem[5] = 16'h1234;
        nextCycle();
        checks++;
        if (a_gnt !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b_prep_write got %b want 1", a_gnt);
        end
        a_req = 1'b0;
        nextCycle();
        b_req = 1'b1; b_addr = 4'd5;
        bQ.push_back(expMem[5]);
        nextCycle();
        checks++;
        if ({b_gnt, a_gnt, rf_we, rf_addr} !== {3'b100, 4'd5}) begin
            errors++;
            $display("[TB] FAIL b_read_gnt got %b/%b/%b/%h want 1/0/0/5", b_gnt, a_gnt, rf_we, rf_addr);
        end
        b_req = 1'b0;
        nextCycle();
        checks++;
        if (b_rvalid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b_read_rvalid got %b want 1", b_rvalid);
        end else begin
            expData = bQ.pop_front();
            checks++;
            if (b_rdata !== expData) begin
                errors++;
                $display("[TB] FAIL b_read_data got %h want %h", b_rdata, expData);
            end
        end
    endtask

    task automatic test_contention;
        logic [DATA_W-1:0] expData;
        logic expA, expB, aRvExp, bRvExp;
        reset_n = 1'b0;
        nextCycle();
        reset_n = 1'b1;
        nextCycle();
        a_req = 1'b1; a_we = 1'b0; a_addr = 4'd3;
        b_req = 1'b1; b_addr = 4'd5;
        aRvExp = 1'b0; bRvExp = 1'b0;
        for (int k = 0; k < 7; k++) begin
            nextCycle();
            expA = (k < 6) && (k % 2 == 0);
            expB = (k < 6) && (k % 2 == 1);
            checks++;
            if ({a_gnt, b_gnt} !== {expA, expB}) begin
                errors++;
                $display("[TB] FAIL contention_gnt k=%0d got %b%b want %b%b", k, a_gnt, b_gnt, expA, expB);
            end
            checks++;
            if ({a_rvalid, b_rvalid} !== {aRvExp, bRvExp}) begin
                errors++;
                $display("[TB] FAIL contention_rvalid k=%0d got %b%b want %b%b",
                         k, a_rvalid, b_rvalid, aRvExp, bRvExp);
            end
            if (a_rvalid && aQ.size() > 0) begin
                expData = aQ.pop_front();
                checks++;
                if (a_rdata !== expData) begin
                    errors++;
                    $display("[TB] FAIL contention_adata got %h want %h", a_rdata, expData);
                end
            end
            if (b_rvalid && bQ.size() > 0) begin
                expData = bQ.pop_front();
                checks++;
                if (b_rdata !== expData) begin
                    errors++;
                    $display("[TB] FAIL contention_bdata got %h want %h", b_rdata, expData);
                end
            end
            if (expA) aQ.push_back(expMem[3]);
            if (expB) bQ.push_back(expMem[5]);
            aRvExp = expA;
            bRvExp = expB;
            if (k == 5) begin
                a_req = 1'b0;
                b_req = 1'b0;
            end
        end
    endtask

    task automatic test_clear;
        logic [DATA_W-1:0] expData;
        for (int i = 0; i < NUM_REGS; i++) begin
            a_req = 1'b1; a_we = 1'b1; a_addr = ADDR_W'(i); a_wdata = 16'hFFFF;
            expMem[i] = 16'hFFFF;
            nextCycle();
            checks++;
            if ({a_gnt, rf_we, rf_addr} !== {2'b11, ADDR_W'(i)}) begin
                errors++;
                $display("[TB] FAIL preload i=%0d got %b/%b/%h", i, a_gnt, rf_we, rf_addr);
            end
            a_req = 1'b0;
            nextCycle();
        end
        clear_req = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) expMem[i] = '0;
        nextCycle();
        clear_req = 1'b0;
        checks++;
        if ({clear_busy, rf_we, a_gnt} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL clear_pend got %b want 100", {clear_busy, rf_we, a_gnt});
        end
        for (int k = 0; k < NUM_REGS; k++) begin
            nextCycle();
            checks++;
            if ({clear_busy, rf_we, a_gnt, rf_addr, rf_wdata} !== {3'b110, ADDR_W'(k), 16'h0000}) begin
                errors++;
                $display("[TB] FAIL clear_sweep k=%0d got busy=%b we=%b gnt=%b addr=%h data=%h",
                         k, clear_busy, rf_we, a_gnt, rf_addr, rf_wdata);
            end
            if (k == 0) begin
                a_req = 1'b1; a_we = 1'b1; a_addr = 4'd4; a_wdata = 16'h5A5A;
            end
        end
        nextCycle();
        checks++;
        if ({clear_busy, rf_we, a_gnt} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL clear_end got %b want 000", {clear_busy, rf_we, a_gnt});
        end
        nextCycle();
        checks++;
        if ({a_gnt, rf_we, rf_addr, rf_wdata} !== {2'b11, 4'd4, 16'h5A5A}) begin
            errors++;
            $display("[TB] FAIL clear_resume got %b/%b/%h/%h want 1/1/4/5a5a", a_gnt, rf_we, rf_addr, rf_wdata);
        end
        expMem[4] = 16'h5A5A;
        a_req = 1'b0;
        nextCycle();
        for (int i = 0; i < NUM_REGS; i++) begin
            b_req = 1'b1; b_addr = ADDR_W'(i);
            bQ.push_back(expMem[i]);
            nextCycle();
            b_req = 1'b0;
            nextCycle();
            checks++;
            if (b_rvalid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL clear_readback_rvalid i=%0d got %b want 1", i, b_rvalid);
            end else begin
                expData = bQ.pop_front();
                checks++;
                if (b_rdata !== expData) begin
                    errors++;
                    $display("[TB] FAIL clear_readback i=%0d got %h want %h", i, b_rdata, expData);
                end
            end
        end
    endtask

    task automatic test_clear_busy;
        logic [DATA_W-1:0] expData;
        int weCount, busyEnd;
        b_req = 1'b1; b_addr = 4'd4;
        bQ.push_back(expMem[4]);
        nextCycle();
        checks++;
        if (b_gnt !== 1'b1) begin
            errors++;
            $display("[TB] FAIL busy_b_gnt got %b want 1", b_gnt);
        end
        b_req = 1'b0;
        clear_req = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) expMem[i] = '0;
        nextCycle();
        clear_req = 1'b0;
        checks++;
        if ({b_rvalid, clear_busy} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL busy_inflight got %b want 11", {b_rvalid, clear_busy});
        end else begin
            expData = bQ.pop_front();
            checks++;
            if (b_rdata !== expData) begin
                errors++;
                $display("[TB] FAIL busy_inflight_data got %h want %h", b_rdata, expData);
            end
        end
        weCount = 0;
        busyEnd = -1;
        for (int k = 2; k <= 24; k++) begin
            nextCycle();
            if (k == 6) clear_req = 1'b0;
            if (rf_we) begin
                weCount++;
                checks++;
                if ({rf_addr, rf_wdata} !== {ADDR_W'(weCount - 1), 16'h0000}) begin
                    errors++;
                    $display("[TB] FAIL busy_sweep_write n=%0d got %h/%h", weCount, rf_addr, rf_wdata);
                end
            end
            if (!clear_busy && busyEnd < 0) busyEnd = k;
            if (k == 5) clear_req = 1'b1;
        end
        checks++;
        if (weCount !== NUM_REGS) begin
            errors++;
            $display("[TB] FAIL busy_sweep_len got %0d want %0d", weCount, NUM_REGS);
        end
        checks++;
        if (busyEnd !== 18) begin
            errors++;
            $display("[TB] FAIL busy_end_cycle got %0d want 18", busyEnd);
        end
    endtask

    task automatic test_async_reset;
        logic [DATA_W-1:0] expData;
        a_req = 1'b1; a_we = 1'b1; a_addr = 4'd12; a_wdata = 16'hBEEF;
        expMem[12] = 16'hBEEF;
        nextCycle();
        a_req = 1'b0;
        nextCycle();
        clear_req = 1'b1;
        for (int i = 0; i < 7; i++) expMem[i] = '0;
        nextCycle();
        clear_req = 1'b0;
        for (int k = 0; k < 8; k++) nextCycle();
        checks++;
        if ({rf_we, rf_addr} !== {1'b1, 4'd7}) begin
            errors++;
            $display("[TB] FAIL areset_presweep got %b/%h want 1/7", rf_we, rf_addr);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({a_gnt, a_rvalid, b_gnt, b_rvalid, clear_busy, rf_we, a_rdata, b_rdata, rf_wdata, rf_addr} !== '0) begin
            errors++;
            $display("[TB] FAIL areset_immediate got %b/%b/%b/%b/%b/%b/%h/%h/%h/%h want all 0",
                     a_gnt, a_rvalid, b_gnt, b_rvalid, clear_busy, rf_we, a_rdata, b_rdata, rf_wdata, rf_addr);
        end
        nextCycle();
        reset_n = 1'b1;
        nextCycle();
        checks++;
        if ({rf_we, clear_busy, a_gnt, b_gnt, a_rvalid, b_rvalid} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL areset_release got %b want 000000",
                     {rf_we, clear_busy, a_gnt, b_gnt, a_rvalid, b_rvalid});
        end
        a_req = 1'b1; a_we = 1'b0; a_addr = 4'd12;
        aQ.push_back(expMem[12]);
        nextCycle();
        checks++;
        if ({a_gnt, rf_we, rf_addr, clear_busy} !== {2'b10, 4'd12, 1'b0}) begin
            errors++;
            $display("[TB] FAIL areset_fresh_gnt got %b/%b/%h/%b want 1/0/c/0", a_gnt, rf_we, rf_addr, clear_busy);
        end
        a_req = 1'b0;
        nextCycle();
        checks++;
        if (a_rvalid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL areset_rvalid got %b want 1", a_rvalid);
        end else begin
            expData = aQ.pop_front();
            checks++;
            if (a_rdata !== expData) begin
                errors++;
                $display("[TB] FAIL areset_data got %h want %h", a_rdata, expData);
            end
        end
        nextCycle();
        checks++;
        if ({aQ.size(), bQ.size()} !== 64'd0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain got a=%0d b=%0d want 0/0", aQ.size(), bQ.size());
        end
    endtask

    // Scenario sequence followed by the summary line.
    initial begin
        test_reset();
        test_a_write();
        test_a_read();
        test_b_read();
        test_contention();
        test_clear();
        test_clear_busy();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/regfile_arbiter.md
Name: regfile_arbiter

Overview:
- Shares the single port of the 16x16 register file between two requesters: port A (CPU datapath, read/write) and port B (LCD/display scanner, read-only).
- Also sequences the CLEAR operation as a 16-cycle zero-write sweep.
- Sits between the CPU control FSM / LCD driver and the register file.
- Owns all register-file address, write-data and write-enable signals.

Parameters:
- DATA_W, 16, register width in bits
- ADDR_W, 4, register index width
- NUM_REGS, 16, registers swept by CLEAR; must be at most 2**ADDR_W

Ports:
- clk  in  1  system clock, 50 MHz
- reset_n  in  1  asynchronous active-low reset
- a_req  in  1  port A request; held until a_gnt
- a_we  in  1  port A write (1) or read (0); stable while a_req
- a_addr  in  ADDR_W  port A register index
- a_wdata  in  DATA_W  port A write data
- a_gnt  out  1  one-cycle pulse: A's access is on the register-file bus this cycle
- a_rvalid  out  1  one-cycle pulse: a_rdata valid (reads only)
- a_rdata  out  DATA_W  port A read data
- b_req  in  1  port B read request; held until b_gnt
- b_addr  in  ADDR_W  port B register index
- b_gnt  out  1  one-cycle grant pulse for B
- b_rvalid  out  1  one-cycle pulse: b_rdata valid
- b_rdata  out  DATA_W  port B read data
- clear_req  in  1  one-cycle pulse: zero all registers
- clear_busy  out  1  CLEAR sweep pending or in progress
- rf_addr  out  ADDR_W  register-file address (registered)
- rf_we  out  1  register-file write enable (registered)
- rf_wdata  out  DATA_W  register-file write data (registered)
- rf_rdata  in  DATA_W  register-file combinational read data for rf_addr

Behaviour:
- Reset (async, reset_n=0):
  - All outputs 0; state IDLE; last_grant=B, so A wins the first tie; clear pending flag 0.
  - Reset mid-sweep or mid-access abandons it. No partial pulses after reset releases.
- States:
  - IDLE/SERVE: one access per cycle max.
  - CLEAR: sweep.
- Arbitration, evaluated on edge ending cycle N:
  - Eligible = req high AND that port's gnt not high in cycle N. A requester deasserts req after seeing gnt, so a held req is never double-granted.
  - One eligible: grant it.
  - Both eligible: grant the one not in last_grant (round-robin), then update last_grant.
- Cycle N+1 for the granted port:
  - x_gnt=1; rf_addr/rf_we/rf_wdata carry the access. For B, rf_we is always 0.
  - No grant that cycle: rf_we=0, rf_addr holds its last value.
- Read latency:
  - rf_rdata is sampled at the end of N+1.
  - x_rvalid=1 with x_rdata in N+2. x_rdata holds until the next read for that port.
  - Writes produce no rvalid.
- Throughput:
  - Both ports continuously requesting: grants alternate A,B,A,B back-to-back.
  - Single requester: one access per 2 cycles.
- CLEAR:
  - clear_req high sets pending. clear_busy=1 from the next cycle until the end of the last sweep write.
  - An access already granted, i.e. gnt high this cycle, completes normally. No new grants once pending.
  - Then NUM_REGS consecutive cycles: rf_we=1, rf_wdata=0, rf_addr=0,1,…,NUM_REGS-1.
  - clear_busy drops the cycle after the final write. Arbitration resumes the same cycle clear_busy is low.
  - clear_req while clear_busy=1: ignored.
  - clear_req and a request in the same cycle: CLEAR wins; the request waits, req held.
- Read data return: an rvalid scheduled for N+2 is still delivered even if CLEAR starts in N+2.
- Widths: no arithmetic on data. Sweep counter is ADDR_W+1 bits to detect termination without wrap.

Optional Feature:
- Macro REGFILE_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. A always wins a tie; last_grant is not used. B can starve under continuous A requests, which is acceptable because the CPU requests at most 2 per instruction.
- Undefined (default): round-robin as above.
- CLEAR behaviour is identical in both builds.

Test Plan:
- A write: after reset, a_req=1, a_we=1, a_addr=3, a_wdata=16'h00A5 at cycle 1 → a_gnt and rf_we=1, rf_addr=3, rf_wdata=16'h00A5 at cycle 2; no a_rvalid.
- A read: rf model holds reg3=16'h00A5; A reads addr 3 → a_gnt cycle 2, a_rvalid=1, a_rdata=16'h00A5 cycle 3; single pulses.
- Contention: a_req and b_req both held continuously from cycle 1 → grants A (c2), B (c3), A (c4), B (c5). With REGFILE_ARB_FIXED_PRIO_EN, A (c2), A (c4), B only on A's gap cycles (c3, c5).
- Clear: preload regs with 16'hFFFF; clear_req pulse at cycle 10 → clear_busy cycles 11–27; zero writes to addr 0..15 on 16 consecutive cycles; all regs 0; a_req held at cycle 12 is granted only after clear_busy falls.
- Clear while busy: second clear_req at cycle 15 → sweep length unchanged (16 writes); in-flight B read granted at cycle 10 still returns b_rvalid at cycle 11.
- Async reset: reset_n low mid-sweep at addr 7 → all outputs 0 immediately; after release no rf_we, state IDLE, and a fresh a_req is granted 1 cycle later.
